p3_datapath_seq: RTL and testbench

Multi-cycle execute sequencer wrapped around the 8x16 register file of the Simple RISC Machine datapath. It accepts one register-to-register operation per request. It drives the register file read port in two consecutive cycles to fetch operands into latches A and B. It then runs B through a shifter and an ALU, latches result C and the status flags, and writes C back through the register file write port. It produces readnum, writenum, write and data_in for the register file, and consumes its combinational data_out.

---
 rtl/p3_dp_pkg.sv | 30 +++
 rtl/p3_shift_alu.sv | 54 +++++
 rtl/p3_datapath_seq.sv | 143 ++++++++++++++
 tb/tb_p3_datapath_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/p3_dp_pkg.sv
// Shared encodings for the Simple RISC Machine execute sequencer:
// ALU operations, B-operand shifts and sequencer states.
package p3_dp_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 3;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_MVN = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ_A = 3'd1,
    ST_READ_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4
  } state_e;

endpackage

// File: rtl/p3_shift_alu.sv
// Combinational shifter + ALU: shifts B by one position, then combines
// it with A and derives zero/negative/signed-overflow status.
module p3_shift_alu
  import p3_dp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  shift_e            shift,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] c,
  output logic              z,
  output logic              n,
  output logic              v
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] bs;

  always_comb begin
    bs = b;
    case (shift)
      SH_LSL:  bs = {b[MSB-1:0], 1'b0};
      SH_LSR:  bs = {1'b0, b[MSB:1]};
      SH_ASR:  bs = {b[MSB], b[MSB:1]};
      default: bs = b;
    endcase
  end

  // Overflow only exists for the arithmetic ops; logic ops report V=0.
  always_comb begin
    c = '0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        c = a + bs;
        v = (a[MSB] == bs[MSB]) && (c[MSB] != a[MSB]);
      end
      OP_SUB: begin
        c = a - bs;
        v = (a[MSB] != bs[MSB]) && (c[MSB] != a[MSB]);
      end
      OP_AND:  c = a & bs;
      OP_MVN:  c = ~bs;
      default: c = '0;
    endcase
  end

  assign z = (c == '0);
  assign n = c[MSB];

endmodule

// File: rtl/p3_datapath_seq.sv
// Multi-cycle execute sequencer: reads A then B from the register file,
// runs the shift/ALU stage, latches C and flags, then writes C back.
module p3_datapath_seq
  import p3_dp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [1:0]        req_shift,
  input  logic              req_asel,
  input  logic              req_wb,
  input  logic [REG_AW-1:0] req_rn,
  input  logic [REG_AW-1:0] req_rm,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [REG_AW-1:0] readnum,
  output logic [REG_AW-1:0] writenum,
  output logic              write,
  output logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v,
  output logic              done
);

  state_e state, next_state;

  alu_op_e           op_q;
  shift_e            shift_q;
  logic              asel_q;
  logic              wb_q;
  logic [REG_AW-1:0] rm_q;
  logic [REG_AW-1:0] rd_q;

  logic [DATA_W-1:0] a_q, b_q, c_q;
  logic [DATA_W-1:0] alu_c;
  logic              alu_z, alu_n, alu_v;

  logic accept;

  assign accept = (state == ST_IDLE) && req_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Fixed five-state walk; only IDLE waits on the request.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (req_valid) next_state = ST_READ_A;
      ST_READ_A: next_state = ST_READ_B;
      ST_READ_B: next_state = ST_EXEC;
      ST_EXEC:   next_state = ST_WB;
      ST_WB:     next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= OP_ADD;
      shift_q <= SH_NONE;
      asel_q  <= 1'b0;
      wb_q    <= 1'b0;
      rm_q    <= '0;
      rd_q    <= '0;
    end else if (accept) begin
      op_q    <= alu_op_e'(req_op);
      shift_q <= shift_e'(req_shift);
      asel_q  <= req_asel;
      wb_q    <= req_wb;
      rm_q    <= req_rm;
      rd_q    <= req_rd;
    end
  end

  // readnum is registered so the register file sees rn throughout READ_A
  // and rm throughout READ_B; it simply holds elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readnum  <= '0;
      writenum <= '0;
    end else begin
      if (accept)
        readnum <= req_rn;
      else if (state == ST_READ_A)
        readnum <= rm_q;
      if ((state == ST_EXEC) && wb_q)
        writenum <= rd_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      case (state)
        ST_READ_A: a_q <= asel_q ? '0 : rf_rdata;
        ST_READ_B: b_q <= rf_rdata;
        ST_EXEC: begin
          c_q    <= alu_c;
          flag_z <= alu_z;
          flag_n <= alu_n;
          flag_v <= alu_v;
        end
        default: ;
      endcase
    end
  end

  p3_shift_alu #(
    .DATA_W(DATA_W)
  ) u_shift_alu (
    .a    (a_q),
    .b    (b_q),
    .shift(shift_q),
    .op   (op_q),
    .c    (alu_c),
    .z    (alu_z),
    .n    (alu_n),
    .v    (alu_v)
  );

  assign req_ready = (state == ST_IDLE);
  assign done      = (state == ST_WB);
  assign write     = (state == ST_WB) && wb_q;
  assign data_in   = c_q;
  assign result    = c_q;

endmodule

// File: tb/tb_p3_datapath_seq.sv
// Self-checking bench for p3_datapath_seq with an 8x16 register file model
// and an arithmetic reference model of each operation.
module tb_p3_datapath_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_shift;
  logic        req_asel;
  logic        req_wb;
  logic [2:0]  req_rn, req_rm, req_rd;
  logic [15:0] rf_rdata;
  logic [2:0]  readnum, writenum;
  logic        write;
  logic [15:0] data_in, result;
  logic        flag_z, flag_n, flag_v;
  logic        done;

  logic [15:0] rf [8];
  logic [15:0] model_rf [8];
  logic        bd_we = 1'b0;
  logic [2:0]  bd_addr = '0;
  logic [15:0] bd_data = '0;

  logic [1:0]  next_op, next_shift;
  logic        next_asel, next_wb;
  logic [2:0]  next_rn, next_rm, next_rd;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  p3_datapath_seq dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_shift(req_shift),
    .req_asel (req_asel),
    .req_wb   (req_wb),
    .req_rn   (req_rn),
    .req_rm   (req_rm),
    .req_rd   (req_rd),
    .rf_rdata (rf_rdata),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .data_in  (data_in),
    .result   (result),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .flag_v   (flag_v),
    .done     (done)
  );

  // Register file: combinational read, write at the rising edge.
  assign rf_rdata = rf[readnum];
  always @(posedge clk) begin
    if (write) rf[writenum] <= data_in;
    if (bd_we) rf[bd_addr] <= bd_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed arithmetic on integers, overflow = result outside 16-bit range.
  function automatic void model_exec(input int op, input int sh, input bit asel,
                                     input int rn, input int rm, output logic [15:0] c,
                                     output bit z, output bit n, output bit v);
    int a, b, bs, sa, sb, r;
    a = asel ? 0 : int'(model_rf[rn]);
    b = int'(model_rf[rm]);
    case (sh)
      1:       bs = (b * 2) % 65536;
      2:       bs = b / 2;
      3:       bs = b / 2 + ((b >= 32768) ? 32768 : 0);
      default: bs = b;
    endcase
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (bs >= 32768) ? bs - 65536 : bs;
    v = 1'b0;
    case (op)
      0: begin r = sa + sb; v = (r > 32767) || (r < -32768); end
      1: begin r = sa - sb; v = (r > 32767) || (r < -32768); end
      2: r = a & bs;
      default: r = 65535 - bs;
    endcase
    c = 16'(r & 32'hFFFF);
    z = (c == 16'h0000);
    n = (c >= 16'h8000);
  endfunction

  task automatic preload(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = addr; bd_data = data;
    model_rf[addr] = data;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic randomize_fields();
    req_op = 2'($urandom_range(0, 3)); req_shift = 2'($urandom_range(0, 3));
    req_asel = 1'($urandom_range(0, 1)); req_wb = 1'($urandom_range(0, 1));
    req_rn = 3'($urandom_range(0, 7)); req_rm = 3'($urandom_range(0, 7));
    req_rd = 3'($urandom_range(0, 7));
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] sh, input logic asel,
                               input logic wb, input logic [2:0] rn, input logic [2:0] rm,
                               input logic [2:0] rd);
    @(negedge clk);
    req_op = op; req_shift = sh; req_asel = asel; req_wb = wb;
    req_rn = rn; req_rm = rm; req_rd = rd; req_valid = 1'b1;
    check("ready_before_accept", req_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic checkOutput(input logic [1:0] op, input logic [1:0] sh, input logic asel,
                             input logic wb, input logic [2:0] rn, input logic [2:0] rm,
                             input logic [2:0] rd, input bit noise, input bit hold);
    logic [15:0] ec;
    bit ez, en, ev, seen;
    int cyc;
    model_exec(op, sh, asel, rn, rm, ec, ez, en, ev);
    applyStimulus(op, sh, asel, wb, rn, rm, rd);
    req_valid = noise;
    if (noise) randomize_fields();
    cyc = 0; seen = 0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1;
      else begin
        check("write_while_busy", write, 0);
        if (noise) begin req_valid = 1'($urandom_range(0, 1)); randomize_fields(); end
      end
    end
    check("done_latency", cyc, 4);
    check("write_in_wb", write, wb);
    if (wb) check("writenum", writenum, rd);
    check("data_in", data_in, ec);
    check("result", result, ec);
    check("flags_znv", {flag_z, flag_n, flag_v}, {ez, en, ev});
    if (hold) begin
      req_op = next_op; req_shift = next_shift; req_asel = next_asel; req_wb = next_wb;
      req_rn = next_rn; req_rm = next_rm; req_rd = next_rd; req_valid = 1'b1;
    end else req_valid = 1'b0;
    @(posedge clk);
    if (wb) model_rf[rd] = ec;
    #1;
    check("rf_rd_after_wb", rf[rd], model_rf[rd]);
    check("ready_after_wb", req_ready, 1);
    check("done_after_wb", done, 0);
  endtask

  task automatic reset_mid(input int at_cycle, input logic [2:0] rd);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 3'd0, 3'd1, rd);
    req_valid = 1'b0;
    for (int i = 0; i < at_cycle; i++) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_write", write, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {flag_z, flag_n, flag_v}, 3'b000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_no_write", rf[rd], model_rf[rd]);
    repeat (3) @(negedge clk);
    check("rst_stays_idle", {req_ready, done, write}, 3'b100);
    check("rst_no_flag_update", {result, flag_z, flag_n, flag_v}, 19'h0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0;
    req_op = '0; req_shift = '0; req_asel = 1'b0; req_wb = 1'b0;
    req_rn = '0; req_rm = '0; req_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {req_ready, write, done, readnum, writenum}, {1'b1, 1'b0, 1'b0, 3'd0, 3'd0});
    check("reset_result", {result, flag_z, flag_n, flag_v}, 19'h0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));

    preload(3'd0, 16'h0003); preload(3'd1, 16'h0005);
    checkOutput(2'b00, 2'b00, 1'b0, 1'b1, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0);
    check("add_r2", rf[2], 16'h0008);

    preload(3'd6, 16'h5555);
    reset_mid(3, 3'd6);
    reset_mid(4, 3'd6);

    preload(3'd0, 16'h8000); preload(3'd1, 16'h0001);
    checkOutput(2'b01, 2'b00, 1'b0, 1'b1, 3'd0, 3'd1, 3'd3, 1'b0, 1'b0);
    check("sub_ovf", {rf[3], flag_v, flag_n, flag_z}, {16'h7FFF, 1'b1, 1'b0, 1'b0});

    preload(3'd4, 16'h8001);
    checkOutput(2'b00, 2'b11, 1'b1, 1'b1, 3'd0, 3'd4, 3'd2, 1'b0, 1'b0);
    check("mov_asr", {rf[2], flag_n}, {16'hC000, 1'b1});
    checkOutput(2'b00, 2'b01, 1'b1, 1'b1, 3'd0, 3'd4, 3'd2, 1'b0, 1'b0);
    check("mov_lsl", rf[2], 16'h0002);
    checkOutput(2'b00, 2'b10, 1'b1, 1'b1, 3'd0, 3'd4, 3'd2, 1'b0, 1'b0);
    check("mov_lsr", rf[2], 16'h4000);

    preload(3'd5, 16'h1234); preload(3'd6, 16'h1234); preload(3'd7, 16'hBEEF);
    checkOutput(2'b01, 2'b00, 1'b0, 1'b0, 3'd5, 3'd6, 3'd7, 1'b0, 1'b0);
    check("cmp_z_r7", {flag_z, rf[7]}, {1'b1, 16'hBEEF});

    preload(3'd0, 16'h0002);
    next_op = 2'b00; next_shift = 2'b00; next_asel = 1'b0; next_wb = 1'b1;
    next_rn = 3'd1; next_rm = 3'd1; next_rd = 3'd2;
    checkOutput(2'b00, 2'b00, 1'b0, 1'b1, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1);
    checkOutput(2'b00, 2'b00, 1'b0, 1'b1, 3'd1, 3'd1, 3'd2, 1'b1, 1'b0);
    check("b2b_r2", rf[2], 16'h0008);

    for (int i = 0; i < 25; i++) begin
      if (i % 5 == 0) preload(3'($urandom_range(0, 7)), 16'($urandom));
      checkOutput(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
